// File: rtl/veda_ram_ctrl.sv
// veda_ram_ctrl: byte-writable single-clock RAM with registered read, valid/error strobes and a post-reset clear sweep.
// Optional macro RAM_WR_BYPASS_EN selects write-first (merged word) for same-cycle same-address read; default is read-first.
module veda_ram_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  writeEnable,
  input  logic [DATA_W/8-1:0]   byteEnable,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     datain,
  input  logic                  readEnable,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     dataout,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int                BYTES   = DATA_W / 8;
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_in, r_in, wr_ok, rd_req, wr_bad;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1, err_p1;

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BYTES-1:0]  be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // The sweep pointer parks on the last word so it never wraps past DEPTH-1.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    busy        = 1'b0;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_ptr == LAST) begin
          state_nxt = IDLE;
        end else begin
          clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign w_in   = {1'b0, waddr} < DEPTH_X;
  assign r_in   = {1'b0, raddr} < DEPTH_X;
  assign wr_ok  = !busy && writeEnable && mode && w_in;
  assign wr_bad = !busy && writeEnable && mode && !w_in;
  assign rd_req = !busy && readEnable;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) begin
        mem[clr_ptr[IDX_W-1:0]] <= INIT_VAL;
      end else if (wr_ok) begin
        mem[waddr[IDX_W-1:0]] <= byte_merge(mem[waddr[IDX_W-1:0]], datain, byteEnable);
      end
    end
  end

  always_comb begin
    rd_word = mem[raddr[IDX_W-1:0]];
`ifdef RAM_WR_BYPASS_EN
    if (wr_ok && (waddr == raddr)) rd_word = byte_merge(rd_word, datain, byteEnable);
`endif
    if (!r_in) rd_word = '0;
  end

  // Stage p1: registered read data, valid and error strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_req;
      err_p1 <= (rd_req && !r_in) || wr_bad;
      if (rd_req) rdata_p1 <= rd_word;
    end
  end

  assign dataout  = rdata_p1;
  assign rd_valid = vld_p1;
  assign addr_err = err_p1;

endmodule
